// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states and
// helpers that derive counter/shift widths from XLEN.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_AND    = 5'd0,
    OP_OR     = 5'd1,
    OP_XOR    = 5'd2,
    OP_ADD    = 5'd3,
    OP_SUB    = 5'd4,
    OP_SLT    = 5'd5,
    OP_SLTU   = 5'd6,
    OP_SEQ    = 5'd7,
    OP_SNE    = 5'd8,
    OP_SGE    = 5'd9,
    OP_SGEU   = 5'd10,
    OP_SLL    = 5'd11,
    OP_SRL    = 5'd12,
    OP_SRA    = 5'd13,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19,
    OP_DIV    = 5'd20,
    OP_DIVU   = 5'd21,
    OP_REM    = 5'd22,
    OP_REMU   = 5'd23
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  function automatic int shamt_width(input int xlen);
    return $clog2(xlen);
  endfunction

  function automatic int cnt_width(input int xlen, input int bpc);
    return $clog2(xlen / bpc);
  endfunction

  // Codes 16..23 are the M-extension group; 24..31 fall back to base ops.
  function automatic logic is_muldiv(input logic [4:0] op);
    return op[4:3] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide on operand
// magnitudes; hi/lo hold product halves or remainder/quotient.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_div,
  input  logic            run,
  input  logic [XLEN-1:0] a_mag,
  input  logic [XLEN-1:0] b_mag,
  output logic            last,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int ITER  = XLEN / BPC;
  localparam int CNT_W = cnt_width(XLEN, BPC);

  logic [XLEN-1:0]  hi_q, lo_q, mcand_q;
  logic [XLEN-1:0]  hi_n, lo_n;
  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q;
  logic [XLEN:0]    sum, rem_sh, diff;

  // hi is the accumulator / partial remainder, lo the multiplier / dividend
  // that fills with quotient bits as it shifts.
  always_comb begin
    hi_n   = hi_q;
    lo_n   = lo_q;
    sum    = '0;
    rem_sh = '0;
    diff   = '0;
    for (int i = 0; i < BPC; i++) begin
      if (is_div_q) begin
        rem_sh = {hi_n, lo_n[XLEN-1]};
        diff   = rem_sh - {1'b0, mcand_q};
        hi_n   = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
        lo_n   = {lo_n[XLEN-2:0], ~diff[XLEN]};
      end else begin
        sum  = {1'b0, hi_n} + (lo_n[0] ? {1'b0, mcand_q} : '0);
        hi_n = sum[XLEN:1];
        lo_n = {sum[0], lo_n[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
    end else if (start) begin
      hi_q     <= '0;
      lo_q     <= a_mag;
      mcand_q  <= b_mag;
      cnt_q    <= '0;
      is_div_q <= is_div;
    end else if (run) begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign last = (cnt_q == CNT_W'(ITER - 1));
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/alu_seq_muldiv.sv
// Handshaked execute-stage ALU: single-cycle base RV32I ops plus iterative
// M-extension multiply/divide, with a held output register.
module alu_seq_muldiv
  import alu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            overflow,
  output logic            busy
);

  localparam int SHAMT_W = shamt_width(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  state_e state, state_n;

  logic            accept, is_m, is_div_op, div_special;
  logic            a_signed, b_signed, sa, sb, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            iter_start, iter_run, iter_last;
  logic [XLEN-1:0] hi, lo;

  logic [4:0]      op_q;
  logic            sa_q, sb_q, div0_q, divovf_q;
  logic [XLEN-1:0] a_q;

  logic            out_valid_q, zero_q, ovf_q;
  logic [XLEN-1:0] result_q;

  assign accept    = in_valid && in_ready;
  assign is_m      = is_muldiv(op);
  assign is_div_op = is_m && op[2];

  assign a_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                    (op == OP_DIV) || (op == OP_REM);
  assign b_signed = (op == OP_MUL) || (op == OP_MULH) ||
                    (op == OP_DIV) || (op == OP_REM);
  assign sa       = a_signed && a[XLEN-1];
  assign sb       = b_signed && b[XLEN-1];
  assign a_mag    = sa ? -a : a;
  assign b_mag    = sb ? -b : b;

  assign div_zero    = (b == '0);
  assign div_ovf     = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_VAL) && (b == '1);
  assign div_special = is_div_op && (div_zero || div_ovf);

  alu_muldiv_iter #(.XLEN(XLEN), .BPC(BITS_PER_CYCLE)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (iter_start),
    .is_div (is_div_op),
    .run    (iter_run),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .last   (iter_last),
    .hi     (hi),
    .lo     (lo)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept && is_m) state_n = div_special ? FIX : (is_div_op ? DIV : MUL);
      MUL,
      DIV:  if (iter_last) state_n = FIX;
      FIX:  state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state == IDLE) && (!out_valid_q || out_ready);
    busy       = (state != IDLE);
    iter_start = (state == IDLE) && in_valid && is_m && (!out_valid_q || out_ready);
    iter_run   = (state == MUL) || (state == DIV);
  end

  // Signs and the raw A are kept so FIX can correct signs and handle the
  // divide special cases without the requester holding its operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      a_q      <= '0;
      div0_q   <= 1'b0;
      divovf_q <= 1'b0;
    end else if (accept && is_m) begin
      op_q     <= op;
      sa_q     <= sa;
      sb_q     <= sb;
      a_q      <= a;
      div0_q   <= is_div_op && div_zero;
      divovf_q <= is_div_op && div_ovf;
    end
  end

  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quot_s, rem_s, fix_res;

  always_comb begin
    prod   = {hi, lo};
    prod_s = (sa_q ^ sb_q) ? -prod : prod;
    quot_s = (sa_q ^ sb_q) ? -lo : lo;
    rem_s  = sa_q ? -hi : hi;
    if (div0_q) begin
      quot_s = '1;
      rem_s  = a_q;
    end else if (divovf_q) begin
      quot_s = MIN_VAL;
      rem_s  = '0;
    end
    case (op_q)
      OP_MUL:                        fix_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fix_res = quot_s;
      OP_REM, OP_REMU:               fix_res = rem_s;
      default:                       fix_res = '0;
    endcase
  end

  logic              sub;
  logic [XLEN-1:0]   b_op, alu_res;
  logic [XLEN:0]     sum;
  logic              carry, add_ovf, lt_s, lt_u;
  logic [SHAMT_W-1:0] shamt;

  // Compares reuse the subtractor: signed via sign^overflow, unsigned via borrow.
  always_comb begin
    sub     = (op != OP_ADD);
    b_op    = sub ? ~b : b;
    sum     = {1'b0, a} + {1'b0, b_op} + {{XLEN{1'b0}}, sub};
    carry   = sum[XLEN];
    add_ovf = (a[XLEN-1] == b_op[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
    lt_s    = sum[XLEN-1] ^ add_ovf;
    lt_u    = ~carry;
    shamt   = b[SHAMT_W-1:0];
    case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_ADD,
      OP_SUB:  alu_res = sum[XLEN-1:0];
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
      OP_SEQ:  alu_res = {{(XLEN-1){1'b0}}, a == b};
      OP_SNE:  alu_res = {{(XLEN-1){1'b0}}, a != b};
      OP_SGE:  alu_res = {{(XLEN-1){1'b0}}, ~lt_s};
      OP_SGEU: alu_res = {{(XLEN-1){1'b0}}, ~lt_u};
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // The output register only changes on a new result or a completed transfer,
  // so it holds steady under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      zero_q      <= 1'b1;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (accept && !is_m) begin
      result_q    <= alu_res;
      zero_q      <= (alu_res == '0);
      ovf_q       <= ((op == OP_ADD) || (op == OP_SUB)) && add_ovf;
      out_valid_q <= 1'b1;
    end else if (state == FIX) begin
      result_q    <= fix_res;
      zero_q      <= (fix_res == '0);
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Scoreboard bench for alu_seq_muldiv: directed vectors push expected results,
// a negedge monitor pops and compares on every output transfer.
module tb_alu_seq_muldiv;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, out_valid, out_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] a, b, result;
  logic            zero, overflow, busy;

  typedef struct {
    logic [XLEN-1:0] res;
    logic            ovf;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cycle = 0;

  alu_seq_muldiv #(.XLEN(XLEN), .BITS_PER_CYCLE(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [XLEN-1:0] act,
                             input logic [XLEN-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Scoreboard monitor: compares every transferred result in issue order.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("sb_result", result, e.res);
        checkOutput("sb_zero", {31'd0, zero}, {31'd0, e.res == '0});
        checkOutput("sb_overflow", {31'd0, overflow}, {31'd0, e.ovf});
      end
    end
  end

  task automatic applyStimulus(input logic [4:0] o, input logic [XLEN-1:0] aa,
                               input logic [XLEN-1:0] bb, input logic [XLEN-1:0] exp_res,
                               input logic exp_ovf, output int acc);
    int waited;
    op = o; a = aa; b = bb; in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      acc = -1;
    end else begin
      @(posedge clk);
      exp_q.push_back('{exp_res, exp_ovf});
      #1;
      acc = cycle - 1;
      in_valid = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) checkOutput("drain_timeout", exp_q.size(), 32'd0);
  endtask

  initial begin
    int acc, acc1, acc2, acc3, rise, lat, ready_hi, held_bad, n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_zero", {31'd0, zero}, 32'd1);
    checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    $display("[TB] back-to-back base ops");
    applyStimulus(5'd3, 32'd7, 32'd5, 32'd12, 1'b0, acc1);
    applyStimulus(5'd4, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, acc2);
    applyStimulus(5'd13, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, acc3);
    checkOutput("b2b_gap1", acc2 - acc1, 32'd1);
    checkOutput("b2b_gap2", acc3 - acc2, 32'd1);
    waitDrain();

    $display("[TB] overflow and compares");
    applyStimulus(5'd3, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1, acc);
    applyStimulus(5'd5, 32'h8000_0000, 32'd1, 32'd1, 1'b0, acc);
    applyStimulus(5'd6, 32'h8000_0000, 32'd1, 32'd0, 1'b0, acc);
    applyStimulus(5'd10, 32'd3, 32'd3, 32'd1, 1'b0, acc);
    waitDrain();

    $display("[TB] multiply latency");
    applyStimulus(5'd17, 32'hFFFF_FFFD, 32'h4000_0000, 32'hFFFF_FFFF, 1'b0, acc);
    ready_hi = 0; n = 0;
    @(negedge clk);
    while (!out_valid && n < 60) begin
      if (in_ready) ready_hi++;
      n++;
      @(negedge clk);
    end
    lat = cycle - acc;
    checkOutput("mulh_latency", lat, 32'd34);
    checkOutput("mulh_in_ready_low", ready_hi, 32'd0);
    waitDrain();
    applyStimulus(5'd16, 32'hFFFF_FFFD, 32'h4000_0000, 32'h4000_0000, 1'b0, acc);
    waitDrain();

    $display("[TB] divide corner cases");
    applyStimulus(5'd20, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, acc);
    applyStimulus(5'd22, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, acc);
    applyStimulus(5'd21, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, acc);
    applyStimulus(5'd22, 32'd5, 32'd0, 32'd5, 1'b0, acc);
    applyStimulus(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, acc);
    applyStimulus(5'd23, 32'd100, 32'd7, 32'd2, 1'b0, acc);
    waitDrain();

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(5'd3, 32'd3, 32'd4, 32'd7, 1'b0, acc);
    held_bad = 0; ready_hi = 0;
    repeat (5) begin
      @(negedge clk);
      if (!out_valid || result !== 32'd7) held_bad++;
      if (in_ready) ready_hi++;
    end
    checkOutput("bp_result_held", held_bad, 32'd0);
    checkOutput("bp_in_ready_low", ready_hi, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    rise = cycle;
    applyStimulus(5'd2, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1'b0, acc);
    checkOutput("bp_accept_on_rise", acc, rise);
    waitDrain();

    $display("[TB] reset mid-divide");
    applyStimulus(5'd21, 32'd100, 32'd7, 32'd14, 1'b0, acc);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    applyStimulus(5'd3, 32'd1, 32'd1, 32'd2, 1'b0, acc);
    waitDrain();
    repeat (40) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
